chroma_compose: RTL and testbench

Streaming chroma-key compositor at the downstream end of the green-screen path: it detects key-colour (green) pixels in the live camera stream and replaces them with a generated background instead of black. The block sits between the D8M capture pipeline and the VGA output stage. It is a 3-stage pipeline with per-frame mode latching, a scrolling checkerboard background generator and a per-frame keyed-pixel counter.

---
 rtl/chroma_pkg.sv | 19 +
 rtl/bg_pattern_gen.sv | 76 +++++++
 rtl/chroma_compose.sv | 189 ++++++++++++++++++
 tb/tb_chroma_compose.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chroma_pkg.sv
// Shared constants and types for the chroma-key compositor.
package chroma_pkg;

    localparam logic [24:0] THRESH_DEFAULT = 25'h0143DA;

    typedef enum logic [1:0] {
        PASS    = 2'd0,
        BLACK   = 2'd1,
        CHECKER = 2'd2,
        SOLID   = 2'd3
    } mode_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/bg_pattern_gen.sv
// Scrolling checkerboard background: position counters registered with S1,
// chosen checker colour registered with S2 of the compositor pipeline.
module bg_pattern_gen #(
    parameter int          CELL_LOG2   = 4,
    parameter int          SCROLL_STEP = 1,
    parameter logic [23:0] BG_A        = 24'h2040C0,
    parameter logic [23:0] BG_B        = 24'hE0E0E0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eol,
    output logic [23:0] bg_color
);

    localparam int OFF_W = CELL_LOG2 + 1;

    logic [11:0]      x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic [11:0]      x_pix, y_pix;
    logic [OFF_W-1:0] off_q, off_d;
    logic [OFF_W-1:0] x_lo_q, x_lo_d, off_s1_q, off_s1_d;
    logic             ybit_q, ybit_d;
    logic [OFF_W-1:0] xs;
    logic             sel;
    logic [23:0]      bg_q, bg_d;

    always_comb begin
        x_pix    = x_cnt_q;
        y_pix    = y_cnt_q;
        x_cnt_d  = x_cnt_q;
        y_cnt_d  = y_cnt_q;
        off_d    = off_q;
        if (in_valid && in_sof) begin
            x_pix = '0;
            y_pix = '0;
            off_d = off_q + OFF_W'(SCROLL_STEP);
        end
        if (in_valid) begin
            x_cnt_d = in_eol ? 12'd0 : x_pix + 12'd1;
            // sof wins over eol so a one-pixel first line still leaves y at 0
            y_cnt_d = in_sof ? 12'd0 : (in_eol ? y_pix + 12'd1 : y_pix);
        end
        // Only the low OFF_W bits of x matter: the offset wraps at 2^OFF_W.
        x_lo_d   = x_pix[OFF_W-1:0];
        ybit_d   = y_pix[CELL_LOG2];
        off_s1_d = off_d;

        xs   = x_lo_q + off_s1_q;
        sel  = ((xs >> CELL_LOG2) != '0) ^ ybit_q;
        bg_d = sel ? BG_B : BG_A;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_cnt_q  <= '0;
            y_cnt_q  <= '0;
            off_q    <= '0;
            x_lo_q   <= '0;
            off_s1_q <= '0;
            ybit_q   <= 1'b0;
            bg_q     <= '0;
        end else begin
            x_cnt_q  <= x_cnt_d;
            y_cnt_q  <= y_cnt_d;
            off_q    <= off_d;
            x_lo_q   <= x_lo_d;
            off_s1_q <= off_s1_d;
            ybit_q   <= ybit_d;
            bg_q     <= bg_d;
        end
    end

    assign bg_color = bg_q;

endmodule

// File: rtl/chroma_compose.sv
// Three-stage chroma-key compositor: green detection, background substitution
// and a per-frame keyed-pixel count. No backpressure; one pixel per clock.
module chroma_compose
    import chroma_pkg::*;
#(
    parameter logic [24:0] THRESH      = THRESH_DEFAULT,
    parameter int          CELL_LOG2   = 4,
    parameter int          SCROLL_STEP = 1,
    parameter logic [23:0] BG_A        = 24'h2040C0,
    parameter logic [23:0] BG_B        = 24'hE0E0E0,
    parameter int          CNT_W       = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic [7:0]       in_r,
    input  logic [7:0]       in_g,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol,
    output logic [7:0]       out_r,
    output logic [7:0]       out_g,
    output logic [7:0]       out_b,
    output logic             out_key,
    output logic [CNT_W-1:0] key_count,
    output logic             count_valid
);

    localparam logic signed [24:0] THRESH_S = THRESH;

    logic              v1_q, v1_d, sof1_q, sof1_d, eol1_q, eol1_d;
    rgb_t              pix1_q, pix1_d;
    logic signed [8:0] dr1_q, dr1_d, db1_q, db1_d;
    mode_t             mode1_q, mode1_d, mode_lat_q, mode_lat_d;

    logic               v2_q, v2_d, sof2_q, sof2_d, eol2_q, eol2_d;
    logic               dr_pos2_q, dr_pos2_d;
    rgb_t               pix2_q, pix2_d;
    logic signed [16:0] p1_q, p1_d;
    logic signed [8:0]  db2_q, db2_d;
    logic signed [8:0]  g1_s;
    mode_t              mode2_q, mode2_d;
    logic [23:0]        bg_color;

    logic signed [24:0] green;
    logic               keyed, key;
    logic               out_valid_q, out_valid_d, out_sof_q, out_sof_d;
    logic               out_eol_q, out_eol_d, out_key_q, out_key_d;
    rgb_t               out_rgb_q, out_rgb_d;
    logic [CNT_W-1:0]   acc_q, acc_d, key_count_q, key_count_d;
    logic               count_valid_q, count_valid_d;

    bg_pattern_gen #(
        .CELL_LOG2  (CELL_LOG2),
        .SCROLL_STEP(SCROLL_STEP),
        .BG_A       (BG_A),
        .BG_B       (BG_B)
    ) u_bg (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_sof  (in_sof),
        .in_eol  (in_eol),
        .bg_color(bg_color)
    );

    always_comb begin
        // The sof pixel already uses the newly sampled mode.
        mode_lat_d = (in_valid && in_sof) ? mode_t'(mode) : mode_lat_q;
        v1_d       = in_valid;
        sof1_d     = in_valid && in_sof;
        eol1_d     = in_valid && in_eol;
        pix1_d     = '{r: in_r, g: in_g, b: in_b};
        dr1_d      = $signed({1'b0, in_g}) - $signed({1'b0, in_r});
        db1_d      = $signed({1'b0, in_g}) - $signed({1'b0, in_b});
        mode1_d    = mode_lat_d;

        g1_s       = $signed({1'b0, pix1_q.g});
        v2_d       = v1_q;
        sof2_d     = sof1_q;
        eol2_d     = eol1_q;
        pix2_d     = pix1_q;
        p1_d       = 17'(g1_s) * 17'(dr1_q);
        dr_pos2_d  = dr1_q > 9'sd0;
        db2_d      = db1_q;
        mode2_d    = mode1_q;

        // Sign gate keeps two negative differences from looking green.
        green = 25'(p1_q) * 25'(db2_q);
        keyed = dr_pos2_q && (db2_q > 9'sd0) && (green > THRESH_S);
        key   = v2_q && keyed && (mode2_q != PASS);

        out_valid_d = v2_q;
        out_sof_d   = sof2_q;
        out_eol_d   = eol2_q;
        out_key_d   = key;
        out_rgb_d   = pix2_q;
        if (key) begin
            case (mode2_q)
                BLACK:   out_rgb_d = '0;
                CHECKER: out_rgb_d = bg_color;
                SOLID:   out_rgb_d = BG_A;
                default: out_rgb_d = pix2_q;
            endcase
        end

        acc_d         = acc_q;
        key_count_d   = key_count_q;
        count_valid_d = 1'b0;
        if (v2_q) begin
            if (sof2_q) begin
                key_count_d   = acc_q;
                count_valid_d = 1'b1;
                acc_d         = CNT_W'(key);
            end else if (key && (acc_q != '1)) begin
                acc_d = acc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_lat_q    <= PASS;
            v1_q          <= 1'b0;
            sof1_q        <= 1'b0;
            eol1_q        <= 1'b0;
            pix1_q        <= '0;
            dr1_q         <= '0;
            db1_q         <= '0;
            mode1_q       <= PASS;
            v2_q          <= 1'b0;
            sof2_q        <= 1'b0;
            eol2_q        <= 1'b0;
            pix2_q        <= '0;
            p1_q          <= '0;
            dr_pos2_q     <= 1'b0;
            db2_q         <= '0;
            mode2_q       <= PASS;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            out_eol_q     <= 1'b0;
            out_key_q     <= 1'b0;
            out_rgb_q     <= '0;
            acc_q         <= '0;
            key_count_q   <= '0;
            count_valid_q <= 1'b0;
        end else begin
            mode_lat_q    <= mode_lat_d;
            v1_q          <= v1_d;
            sof1_q        <= sof1_d;
            eol1_q        <= eol1_d;
            pix1_q        <= pix1_d;
            dr1_q         <= dr1_d;
            db1_q         <= db1_d;
            mode1_q       <= mode1_d;
            v2_q          <= v2_d;
            sof2_q        <= sof2_d;
            eol2_q        <= eol2_d;
            pix2_q        <= pix2_d;
            p1_q          <= p1_d;
            dr_pos2_q     <= dr_pos2_d;
            db2_q         <= db2_d;
            mode2_q       <= mode2_d;
            out_valid_q   <= out_valid_d;
            out_sof_q     <= out_sof_d;
            out_eol_q     <= out_eol_d;
            out_key_q     <= out_key_d;
            out_rgb_q     <= out_rgb_d;
            acc_q         <= acc_d;
            key_count_q   <= key_count_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_sof     = out_sof_q;
    assign out_eol     = out_eol_q;
    assign out_r       = out_rgb_q.r;
    assign out_g       = out_rgb_q.g;
    assign out_b       = out_rgb_q.b;
    assign out_key     = out_key_q;
    assign key_count   = key_count_q;
    assign count_valid = count_valid_q;

endmodule

// File: tb/tb_chroma_compose.sv
// Bench for chroma_compose: frame-level reference model feeding an expected
// queue, checked every clock, plus hand-computed spot values.
module tb_chroma_compose;

    localparam int          CNT_W = 22;
    localparam logic [23:0] BG_A  = 24'h2040C0;
    localparam logic [23:0] BG_B  = 24'hE0E0E0;

    logic             clk, rst;
    logic [1:0]       mode;
    logic             in_valid, in_sof, in_eol;
    logic [7:0]       in_r, in_g, in_b;
    logic             out_valid, out_sof, out_eol, out_key, count_valid;
    logic [7:0]       out_r, out_g, out_b;
    logic [CNT_W-1:0] key_count;

    chroma_compose dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_eol     (in_eol),
        .in_r       (in_r),
        .in_g       (in_g),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b),
        .out_key    (out_key),
        .key_count  (key_count),
        .count_valid(count_valid)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic             zero;
        logic             v;
        logic             sof;
        logic             eol;
        logic             key;
        logic             cv;
        logic [23:0]      rgb;
        logic [CNT_W-1:0] kc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    logic [23:0] cap_q[$];
    logic        cap_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          cv_cnt = 0;
    int          last_kc = -1;

    int m_x, m_y, m_nsof, m_mode, m_acc, m_kc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int greenness(input int r, input int g, input int b);
        return g * (g - r) * (g - b);
    endfunction

    function automatic bit is_keyed(input int r, input int g, input int b);
        return ((g - r) > 0) && ((g - b) > 0) && (greenness(r, g, b) > 82906);
    endfunction

    // Called once per rising edge with the inputs the DUT just sampled.
    task automatic model_step();
        exp_t e;
        int   r, g, b, x, y, off, xs;
        cyc++;
        if (rst) begin
            exp_q.delete();
            e = '0;
            e.zero = 1'b1;
            exp_q.push_back(e);
            e.zero = 1'b0;
            exp_q.push_back(e);
            exp_q.push_back(e);
            m_x = 0; m_y = 0; m_nsof = 0; m_mode = 0; m_acc = 0; m_kc = 0;
            return;
        end
        e = '0;
        e.kc = CNT_W'(m_kc);
        if (in_valid) begin
            r = int'(in_r); g = int'(in_g); b = int'(in_b);
            if (in_sof) begin
                m_mode = int'(mode);
                m_nsof++;
                m_x = 0;
                m_y = 0;
                m_kc = m_acc;
                e.kc = CNT_W'(m_acc);
                e.cv = 1'b1;
                m_acc = 0;
            end
            x   = m_x;
            y   = m_y;
            off = m_nsof % 32;
            e.v   = 1'b1;
            e.sof = in_sof;
            e.eol = in_eol;
            e.key = (m_mode != 0) && is_keyed(r, g, b);
            e.rgb = {in_r, in_g, in_b};
            if (e.key) begin
                xs = (x + off) % 4096;
                case (m_mode)
                    1:       e.rgb = 24'h000000;
                    2:       e.rgb = ((((xs >> 4) & 1) ^ ((y >> 4) & 1)) == 1) ? BG_B : BG_A;
                    default: e.rgb = BG_A;
                endcase
                if (m_acc < (1 << CNT_W) - 1) m_acc++;
            end
            if (in_eol) begin
                m_x = 0;
                m_y = in_sof ? 0 : (y + 1) % 4096;
            end else begin
                m_x = (x + 1) % 4096;
            end
        end
        exp_q.push_back(e);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got no expectation, expected one (cycle %0d)", cyc);
            end else begin
                ce = exp_q.pop_front();
                chk("out_valid", 32'(out_valid), 32'(ce.v));
                chk("count_valid", 32'(count_valid), 32'(ce.cv));
                chk("key_count", 32'(key_count), 32'(ce.kc));
                if (ce.v || ce.zero) begin
                    chk("out_sof", 32'(out_sof), 32'(ce.sof));
                    chk("out_eol", 32'(out_eol), 32'(ce.eol));
                    chk("out_key", 32'(out_key), 32'(ce.key));
                    chk("out_rgb", 32'({out_r, out_g, out_b}), 32'(ce.rgb));
                end
            end
            if (count_valid) begin
                last_kc = int'(key_count);
                cv_cnt++;
            end
            if (cap_en && out_valid) cap_q.push_back({out_r, out_g, out_b});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic px(input bit v, input bit s, input bit e,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        in_valid = v; in_sof = s; in_eol = e;
        in_r = r; in_g = g; in_b = b;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) px(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    // pat 0: pure green; 1: random mix with occasional mode change; 2: first 37 keyed
    task automatic frame(input int w, input int h, input int pat, input int gap);
        logic [7:0] r, g, b;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                if (gap > 0) idle(int'($urandom_range(0, gap)));
                if (pat == 0) begin
                    r = 8'd0; g = 8'hFF; b = 8'd0;
                end else if (pat == 2) begin
                    if (yy * w + xx < 37) begin r = 8'd0; g = 8'hFF; b = 8'd0; end
                    else begin r = 8'd128; g = 8'd128; b = 8'd128; end
                end else begin
                    if ($urandom_range(0, 1) == 1) begin
                        r = 8'($urandom_range(0, 70));
                        g = 8'($urandom_range(40, 255));
                        b = 8'($urandom_range(0, 70));
                    end else begin
                        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
                    end
                    if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
                end
                px(1'b1, (xx == 0) && (yy == 0), xx == w - 1, r, g, b);
            end
        end
    endtask

    // ---------------- test sequence ----------------
    int cv0;

    initial begin
        rst = 1'b1; mode = 2'd0;
        in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
        do_reset(3);

        chk("model_green_a", 32'(greenness(10, 200, 10)), 32'd7220000);
        chk("model_green_b", 32'(greenness(100, 120, 100)), 32'd48000);
        chk("model_key_a", 32'(is_keyed(10, 200, 10)), 32'd1);
        chk("model_key_b", 32'(is_keyed(100, 120, 100)), 32'd0);
        chk("model_key_sign", 32'(is_keyed(250, 5, 250)), 32'd0);

        // Directed keying and sign gate, first frames after reset
        cap_en = 1'b1;
        mode = 2'd2;
        px(1'b1, 1'b1, 1'b0, 8'd10, 8'd200, 8'd10);
        px(1'b1, 1'b0, 1'b1, 8'd100, 8'd120, 8'd100);
        mode = 2'd1;
        px(1'b1, 1'b1, 1'b0, 8'd250, 8'd5, 8'd250);
        px(1'b1, 1'b0, 1'b1, 8'd0, 8'd255, 8'd0);
        idle(5);
        cap_en = 1'b0;
        chk("dir_cap_size", 32'(cap_q.size()), 32'd4);
        chk("dir_keyed_checker", 32'(cap_q[0]), 32'(BG_A));
        chk("dir_pass", 32'(cap_q[1]), 32'h647864);
        chk("dir_sign_gate", 32'(cap_q[2]), 32'hFA05FA);
        chk("dir_black", 32'(cap_q[3]), 32'h000000);

        // Checker geometry: two 64x4 green frames, offsets 1 then 2
        do_reset(2);
        cap_q.delete();
        cap_en = 1'b1;
        mode = 2'd2;
        frame(64, 4, 0, 0);
        frame(64, 4, 0, 0);
        idle(5);
        cap_en = 1'b0;
        chk("chk_cap_size", 32'(cap_q.size()), 32'd512);
        chk("chk_f1_x0", 32'(cap_q[0]), 32'(BG_A));
        chk("chk_f1_x14", 32'(cap_q[14]), 32'(BG_A));
        chk("chk_f1_x15", 32'(cap_q[15]), 32'(BG_B));
        chk("chk_f1_x30", 32'(cap_q[30]), 32'(BG_B));
        chk("chk_f1_x31", 32'(cap_q[31]), 32'(BG_A));
        chk("chk_f2_x13", 32'(cap_q[256 + 13]), 32'(BG_A));
        chk("chk_f2_x14", 32'(cap_q[256 + 14]), 32'(BG_B));

        // Tall narrow frame crosses a vertical cell boundary
        frame(3, 20, 0, 0);

        // Counting: 37 keyed pixels among bubbles
        frame(16, 4, 2, 2);
        cv0 = cv_cnt;
        frame(8, 1, 0, 1);
        idle(5);
        chk("count_37", 32'(last_kc), 32'd37);
        chk("count_pulse_once", 32'(cv_cnt - cv0), 32'd1);

        // Mode latch: change to pass-through mid-frame
        mode = 2'd2;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) mode = 2'd0;
            px(1'b1, i == 0, (i % 8) == 7, 8'd0, 8'd255, 8'd0);
        end
        frame(8, 2, 0, 1);
        idle(5);
        chk("latch_count_keyed", 32'(last_kc), 32'd16);
        frame(4, 1, 0, 0);
        idle(5);
        chk("latch_count_pass", 32'(last_kc), 32'd0);

        // Reset with pixels in flight
        mode = 2'd3;
        px(1'b1, 1'b1, 1'b0, 8'd0, 8'd255, 8'd0);
        for (int i = 0; i < 5; i++) px(1'b1, 1'b0, 1'b0, 8'd0, 8'd255, 8'd0);
        do_reset(1);
        cap_q.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 4; i++) px(1'b1, 1'b0, i == 3, 8'd0, 8'd255, 8'd0);
        idle(5);
        cap_en = 1'b0;
        chk("rst_cap_size", 32'(cap_q.size()), 32'd4);
        chk("rst_mode_pass", 32'(cap_q[0]), 32'h00FF00);
        frame(4, 1, 0, 0);
        idle(5);
        chk("rst_count_zero", 32'(last_kc), 32'd0);

        // Randomized frames, gaps, one-pixel lines and mid-frame mode changes
        for (int f = 0; f < 12; f++) begin
            mode = 2'($urandom_range(0, 3));
            frame(int'($urandom_range(1, 24)), int'($urandom_range(1, 3)), 1, 2);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
